// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the IF/MEM pipeline stages, the shared memory and the port arbiter.
// The arbiter uses the slave modport; the requesters and memory model sit on the master side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;

    logic              mem_valid;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic              bus_err;

    modport slave (
        input  if_req, if_addr,
        output if_rdata, if_ready,
        input  d_req, d_we, d_addr, d_wdata,
        output d_rdata, d_ready,
        output mem_valid, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready,
        output bus_err
    );

    modport master (
        output if_req, if_addr,
        input  if_rdata, if_ready,
        output d_req, d_we, d_addr, d_wdata,
        input  d_rdata, d_ready,
        input  mem_valid, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready,
        input  bus_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store, with a timeout watchdog.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise data has fixed priority over fetch.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input logic               clk,
    input logic               reset_n,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        D_BUSY  = 2'd2
    } state_t;

    localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t state;
    state_t state_nxt;

    logic [ADDR_W-1:0]  cmd_addr;
    logic               cmd_we;
    logic [DATA_W-1:0]  cmd_wdata;
    logic [TIMER_W-1:0] timer;
    logic               bus_err_q;

    logic busy;
    logic grant_d;
    logic grant_if;
    logic timeout_hit;
    logic done;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_d;
`endif

    assign busy = (state != IDLE);

    // Grant decision is only meaningful in IDLE; a transaction in flight is never preempted.
    always_comb begin
        grant_d  = 1'b0;
        grant_if = 1'b0;
        if (state == IDLE) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (bus.d_req && bus.if_req) begin
                if (last_grant_d) grant_if = 1'b1;
                else              grant_d  = 1'b1;
            end else if (bus.d_req) begin
                grant_d = 1'b1;
            end else if (bus.if_req) begin
                grant_if = 1'b1;
            end
`else
            if (bus.d_req)       grant_d  = 1'b1;
            else if (bus.if_req) grant_if = 1'b1;
`endif
        end
    end

    // A TIMEOUT of zero disables the watchdog entirely.
    always_comb begin
        timeout_hit = 1'b0;
        if (TIMEOUT != 0 && busy && !bus.mem_ready && timer == TIMER_W'(TIMEOUT - 1))
            timeout_hit = 1'b1;
    end

    assign done = busy && (bus.mem_ready || timeout_hit);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_d)       state_nxt = D_BUSY;
                else if (grant_if) state_nxt = IF_BUSY;
            end
            IF_BUSY, D_BUSY: begin
                if (done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Command registers freeze the request at grant so requester-side changes cannot disturb memory.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_addr  <= '0;
            cmd_we    <= 1'b0;
            cmd_wdata <= '0;
        end else if (grant_d) begin
            cmd_addr  <= bus.d_addr;
            cmd_we    <= bus.d_we;
            cmd_wdata <= bus.d_wdata;
        end else if (grant_if) begin
            cmd_addr  <= bus.if_addr;
            cmd_we    <= 1'b0;
            cmd_wdata <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            if (grant_d || grant_if)
                timer <= '0;
            else if (busy && !bus.mem_ready)
                timer <= timer + 1'b1;
            if (timeout_hit)
                bus_err_q <= 1'b1;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      last_grant_d <= 1'b0;
        else if (grant_d)  last_grant_d <= 1'b1;
        else if (grant_if) last_grant_d <= 1'b0;
    end
`endif

    // Completion data is a combinational pass-through; a watchdog abort returns zero data.
    always_comb begin
        bus.mem_valid = busy;
        bus.mem_we    = busy && cmd_we;
        bus.mem_addr  = cmd_addr;
        bus.mem_wdata = cmd_wdata;
        bus.if_ready  = (state == IF_BUSY) && done;
        bus.d_ready   = (state == D_BUSY) && done;
        bus.if_rdata  = '0;
        bus.d_rdata   = '0;
        if (state == IF_BUSY && bus.mem_ready)
            bus.if_rdata = bus.mem_rdata;
        if (state == D_BUSY && bus.mem_ready && !cmd_we)
            bus.d_rdata = bus.mem_rdata;
        bus.bus_err   = bus_err_q;
    end

endmodule
